// File: rtl/name_compress.sv
// name_compress: run-length compressor for fixed-width name strings.
// Collapses consecutive identical strings into {count, string} records.
module name_compress #(
  parameter int STR_W = 128,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STR_W-1:0]       InString,
  output logic [CNT_W+STR_W-1:0] Out,
  output logic                   write,
  output logic [STR_W-1:0]       strcmp0,
  output logic [STR_W-1:0]       strcmp1
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [STR_W-1:0]       strcmp0_q, strcmp0_d;
  logic [STR_W-1:0]       strcmp1_q, strcmp1_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W+STR_W-1:0] out_q, out_d;
  logic                   write_q, write_d;

  logic same;
  logic live;
  logic sat;

  assign same = (strcmp0_q == strcmp1_q);
  assign live = (strcmp1_q != '0);
  assign sat  = (count_q == '1);

  // Next state: shift the compare pipeline and close a run on change or saturation
  always_comb begin
    strcmp0_d = InString;
    strcmp1_d = strcmp0_q;
    count_d   = count_q;
    out_d     = out_q;
    write_d   = 1'b0;
    if (same && !sat) begin
      count_d = count_q + ONE;
    end else begin
      // A run closes here; the zero (idle) string never produces a record.
      count_d = ONE;
      if (live) begin
        write_d = 1'b1;
        out_d   = {count_q, strcmp1_q};
      end
    end
  end

  // State registers with synchronous reset that discards any open run
  always_ff @(posedge clk) begin
    if (rst) begin
      strcmp0_q <= '0;
      strcmp1_q <= '0;
      count_q   <= '0;
      out_q     <= '0;
      write_q   <= 1'b0;
    end else begin
      strcmp0_q <= strcmp0_d;
      strcmp1_q <= strcmp1_d;
      count_q   <= count_d;
      out_q     <= out_d;
      write_q   <= write_d;
    end
  end

  assign Out     = out_q;
  assign write   = write_q;
  assign strcmp0 = strcmp0_q;
  assign strcmp1 = strcmp1_q;

endmodule

// File: tb/tb_name_compress.sv
// tb_name_compress: scoreboard bench for name_compress.
// Expected records are queued by the stimulus and popped by monitors.
module tb_name_compress;

  localparam logic [127:0] SA = 128'hAAAAAAAAAA;
  localparam logic [127:0] SB = 128'hBBBBBBBBBB;
  localparam logic [127:0] SC = 128'hCCCCCCCCCC;
  localparam logic [127:0] SL = 128'h6c6c6c6c6c6c6c6c6c6c;
  localparam logic [127:0] SX = 128'h123456789ABCDEF0;

  typedef struct {
    logic [159:0] rec;
    int           due;
  } exp_t;

  typedef struct {
    logic [131:0] rec;
    int           due;
  } sexp_t;

  logic         clk;
  logic         rst;
  logic [127:0] InString;
  logic [159:0] Out;
  logic         write;
  logic [127:0] strcmp0;
  logic [127:0] strcmp1;

  logic [127:0] sat_in;
  logic [131:0] sat_out;
  logic         sat_write;
  logic [127:0] sat_s0;
  logic [127:0] sat_s1;

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  exp_t  q[$];
  sexp_t sq[$];

  name_compress dut (
    .clk      (clk),
    .rst      (rst),
    .InString (InString),
    .Out      (Out),
    .write    (write),
    .strcmp0  (strcmp0),
    .strcmp1  (strcmp1)
  );

  name_compress #(.STR_W(128), .CNT_W(4)) u_sat (
    .clk      (clk),
    .rst      (rst),
    .InString (sat_in),
    .Out      (sat_out),
    .write    (sat_write),
    .strcmp0  (sat_s0),
    .strcmp1  (sat_s1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic r, input logic [127:0] v,
                      input logic [127:0] sv);
    @(negedge clk);
    rst      = r;
    InString = v;
    sat_in   = sv;
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic go(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) step(1'b0, v, '0);
  endtask

  task automatic expect_rec(input int cnt, input logic [127:0] s);
    exp_t e;
    e.rec = {32'(cnt), s};
    e.due = edges + 2;
    q.push_back(e);
  endtask

  task automatic expect_sat(input int cnt, input logic [127:0] s,
                            input int due);
    sexp_t e;
    e.rec = {4'(cnt), s};
    e.due = due;
    sq.push_back(e);
  endtask

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor for the main instance: every strobe must match the queue head
  always @(negedge clk) begin
    if (write === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got Out=%h at edge %0d, none expected",
                 Out, edges);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (Out !== e.rec || edges != e.due) begin
          errors++;
          $display("FAIL record: got %h at edge %0d expected %h at edge %0d",
                   Out, edges, e.rec, e.due);
        end
      end
    end
  end

  // Monitor for the narrow-count instance used for saturation
  always @(negedge clk) begin
    if (sat_write === 1'b1) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL sat_unexpected_write: got Out=%h at edge %0d",
                 sat_out, edges);
      end else begin
        sexp_t e;
        e = sq.pop_front();
        if (sat_out !== e.rec || edges != e.due) begin
          errors++;
          $display("FAIL sat_record: got %h at edge %0d expected %h at edge %0d",
                   sat_out, edges, e.rec, e.due);
        end
      end
    end
  end

  initial begin
    int m;
    rst      = 1'b1;
    InString = '0;
    sat_in   = '0;
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    chk("reset_out", Out, '0);
    chk("reset_write", {159'd0, write}, '0);
    chk("reset_s0", {32'd0, strcmp0}, '0);
    chk("reset_s1", {32'd0, strcmp1}, '0);

    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, '0);
      chk("idle_write", {159'd0, write}, '0);
    end
    chk("idle_out", Out, '0);
    chk("idle_s0", {32'd0, strcmp0}, '0);
    chk("idle_s1", {32'd0, strcmp1}, '0);

    go(SA, 10);
    chk("run_s0", {32'd0, strcmp0}, {32'd0, SA});
    chk("run_s1", {32'd0, strcmp1}, {32'd0, SA});
    expect_rec(10, SA);
    go(SB, 15);
    expect_rec(15, SB);
    go(SC, 1);
    expect_rec(1, SC);
    go(SA, 5);
    expect_rec(5, SA);
    go(SL, 4);
    expect_rec(4, SL);
    go(SA, 1);
    expect_rec(1, SA);
    go(SB, 1);
    expect_rec(1, SB);
    go(SA, 1);
    expect_rec(1, SA);
    go(SB, 1);
    expect_rec(1, SB);
    go('0, 4);

    go(SA, 3);
    step(1'b1, SA, '0);
    chk("midrst_out", Out, '0);
    chk("midrst_write", {159'd0, write}, '0);
    chk("midrst_s0", {32'd0, strcmp0}, '0);
    go(SA, 3);
    expect_rec(3, SA);
    go(SB, 1);
    expect_rec(1, SB);
    go('0, 4);

    m = edges;
    expect_sat(15, SX, m + 17);
    expect_sat(15, SX, m + 32);
    expect_sat(10, SX, m + 42);
    for (int i = 0; i < 40; i++) step(1'b0, '0, SX);
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_main: got %0d pending records expected 0", q.size());
    end
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL drain_sat: got %0d pending records expected 0", sq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
